// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI memory completer.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  function automatic logic [7:0] bytes_per_beat(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP plus per-beat error for the current address.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  err
);
  localparam int OFF = $clog2(DATA_WIDTH/8);

  logic [ADDR_WIDTH-1:0] step, wrap_mask, incr;
  logic                  bad_wrap_len, out_of_range;

  always_comb begin
    step         = ADDR_WIDTH'(bytes_per_beat(size));
    incr         = addr + step;
    // wrap window is (len+1) beats wide, aligned to its own size
    wrap_mask    = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    bad_wrap_len = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    out_of_range = |(addr >> (MEM_DEPTH_LOG2 + OFF));
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr = incr;
    endcase
    err = (size > 3'(OFF)) | (burst == BURST_RSVD) |
          ((burst == BURST_WRAP) & bad_wrap_len) | out_of_range;
  end

endmodule

// File: rtl/axi_completer_mem.sv
// AXI4 completer backed by a register-array memory; independent write and read engines.
module axi_completer_mem
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int STRB  = DATA_WIDTH/8;
  localparam int OFF   = $clog2(STRB);
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[MEM_DEPTH_LOG2+OFF-1:OFF];
  endfunction

  // ---------------- write engine ----------------
  wr_state_t             w_state, w_nxt;
  logic [ADDR_WIDTH-1:0] w_addr, w_next_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err_acc, w_gen_err, w_beat, w_final, w_beat_err;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                       .MEM_DEPTH_LOG2(MEM_DEPTH_LOG2)) u_w_gen (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst),
    .next_addr(w_next_addr), .err(w_gen_err)
  );

  assign w_beat     = (w_state == W_DATA) & wvalid & wready;
  assign w_final    = (w_cnt == w_len);
  assign w_beat_err = w_gen_err | (wlast != w_final);

  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_IDLE:  if (awvalid & awready) w_nxt = W_DATA;
      W_DATA:  if (w_beat & w_final)  w_nxt = W_RESP;
      W_RESP:  if (bvalid & bready)   w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_nxt;

  // handshake outputs are registered decodes of the next state so they read 0 in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      w_addr    <= '0;
      w_len     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_cnt     <= '0;
      w_err_acc <= 1'b0;
    end else begin
      awready <= (w_nxt == W_IDLE);
      wready  <= (w_nxt == W_DATA);
      bvalid  <= (w_nxt == W_RESP);
      if (awvalid & awready) begin
        w_addr    <= awaddr;
        w_len     <= awlen;
        w_size    <= awsize;
        w_burst   <= awburst;
        w_cnt     <= '0;
        w_err_acc <= 1'b0;
      end
      if (w_beat) begin
        w_addr    <= w_next_addr;
        w_cnt     <= w_cnt + 8'd1;
        w_err_acc <= w_err_acc | w_beat_err;
        if (w_final) bresp <= (w_err_acc | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk)
    if (w_beat & !w_beat_err)
      for (int b = 0; b < STRB; b++)
        if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];

  // ---------------- read engine ----------------
  rd_state_t             r_state, r_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, g_addr, r_next_addr;
  logic [7:0]            r_len, r_cnt, g_len;
  logic [2:0]            r_size, g_size;
  logic [1:0]            r_burst, g_burst;
  logic                  r_gen_err, ar_hs, r_hs;
  logic [DATA_WIDTH-1:0] rd_word;

  // in idle the generator looks at the incoming request so beat 0 is ready on the handshake
  assign g_addr  = (r_state == R_IDLE) ? araddr  : r_addr;
  assign g_len   = (r_state == R_IDLE) ? arlen   : r_len;
  assign g_size  = (r_state == R_IDLE) ? arsize  : r_size;
  assign g_burst = (r_state == R_IDLE) ? arburst : r_burst;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                       .MEM_DEPTH_LOG2(MEM_DEPTH_LOG2)) u_r_gen (
    .addr(g_addr), .size(g_size), .len(g_len), .burst(g_burst),
    .next_addr(r_next_addr), .err(r_gen_err)
  );

  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid & rready;
  assign rd_word = r_gen_err ? '0 : mem[word_idx(g_addr)];

  always_comb begin
    r_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)                   r_nxt = R_DATA;
      R_DATA:  if (r_hs && r_cnt == r_len)  r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else begin
      arready <= (r_nxt == R_IDLE);
      if (ar_hs) begin
        r_addr  <= r_next_addr;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_cnt   <= '0;
        rvalid  <= 1'b1;
        rlast   <= (arlen == 8'd0);
        rresp   <= r_gen_err ? RESP_SLVERR : RESP_OKAY;
        rdata   <= rd_word;
      end else if (r_hs) begin
        if (r_cnt == r_len) begin
          rvalid <= 1'b0;
          rlast  <= 1'b0;
        end else begin
          r_addr <= r_next_addr;
          r_cnt  <= r_cnt + 8'd1;
          rlast  <= ((r_cnt + 8'd1) == r_len);
          rresp  <= r_gen_err ? RESP_SLVERR : RESP_OKAY;
          rdata  <= rd_word;
        end
      end
    end
  end

endmodule

// File: doc/axi_completer_mem.md
Name: axi_completer_mem

Overview:
- AXI4 memory-backed completer (slave) that terminates the RX-side AXI master channels (RX_aw*/RX_w*/RX_b*/RX_ar*/RX_r*) driven by the transaction layer.
- Turns received write/read request TLPs into storage accesses.
- Returns B and R responses, which the transaction layer packs into completion TLPs.
- Independent write and read engines share one register-array memory; one outstanding burst per direction.

Parameters:
- ADDR_WIDTH, 32, byte address width of aw/araddr.
- DATA_WIDTH, 32, data bus width; power of two, 8..128.
- MEM_DEPTH_LOG2, 8, log2 of number of DATA_WIDTH-bit words (default 256 words).

Ports:
- clk  in  1  clock
- rst  in  1  reset, active-low, asynchronous
- awaddr  in  ADDR_WIDTH  write burst start byte address
- awlen  in  8  beats-1
- awsize  in  3  bytes per beat = 2^awsize
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- awvalid  in  1 / awready  out  1  AW handshake
- wdata  in  DATA_WIDTH / wstrb  in  DATA_WIDTH/8 / wlast  in  1  write beat
- wvalid  in  1 / wready  out  1  W handshake
- bresp  out  2 / bvalid  out  1 / bready  in  1  write response
- araddr  in  ADDR_WIDTH / arlen  in  8 / arsize  in  3 / arburst  in  2  read request
- arvalid  in  1 / arready  out  1  AR handshake
- rdata  out  DATA_WIDTH / rresp  out  2 / rlast  out  1  read beat
- rvalid  out  1 / rready  in  1  R handshake

Behaviour:
- Reset (rst=0, async) sets both FSMs to IDLE; awready=arready=wready=bvalid=rvalid=rlast=0; bresp=rresp=0; rdata=0. Memory contents are not reset.
- Word index = addr[MEM_DEPTH_LOG2+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
- Out of range: any upper address bit set.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1 (starting the first cycle after reset release).
  - On awvalid&awready: latch addr/len/size/burst; beat counter=0; go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready beat writes the bytes enabled by wstrb, then advances the address and counter.
  - Beat counter==awlen: go to W_RESP. wlast is not used to end the burst.
  - W_RESP: bvalid=1; bresp held until bready; then W_IDLE.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1.
  - On AR handshake: latch request. Next cycle rvalid=1 with beat-0 data registered; rlast=(arlen==0).
  - rdata/rresp/rlast stay stable while rvalid&!rready.
  - On rvalid&rready: load the next beat's data in the same edge.
  - After the beat with counter==arlen handshakes: rvalid=0, R_IDLE; arready=1 the following cycle.
- Address generation, per beat, with step=2^size:
  - FIXED: address unchanged.
  - INCR: addr+step. No 4 KB check.
  - WRAP: boundary=(len+1)*step. next = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
- SLVERR (2'b10), else OKAY (2'b00):
  - size > log2(DATA_WIDTH/8);
  - burst==11;
  - WRAP with len not in {1,3,7,15};
  - any beat out of range;
  - wlast mismatch: wlast=1 before the final beat, or 0 on the final beat.
  - Write: an error beat does not update memory; the burst still consumes all awlen+1 beats and bresp=SLVERR.
  - Read: per-beat rresp; an error beat returns rdata=0.
- Narrow transfers: the full word is read and returned; writes obey wstrb only, with no lane masking by size.
- Simultaneous write and read of the same word in one cycle: the read beat captures the pre-write data. Write and read engines never stall each other.
- Reset mid-burst aborts both engines immediately. No response is issued for the aborted burst.

Decomposition:
- Package axi_pkg:
  - burst_t enum (FIXED/INCR/WRAP/RSVD);
  - resp constants OKAY=2'b00, SLVERR=2'b10;
  - write/read state enums;
  - function bytes_per_beat.
- Sub-module axi_burst_addr_gen: inputs addr, size, len, burst; outputs next_addr and err. Instantiated once in each engine.

Test Plan:
- INCR write, awaddr=0x10, awlen=3, size=2, wdata 0xA0..0xA3, wstrb=F -> bresp=OKAY. INCR read of the same range -> rdata 0xA0,0xA1,0xA2,0xA3; rlast only on beat 4.
- WRAP read, araddr=0x18, arlen=3, size=2 -> addresses 0x18,0x1C,0x10,0x14; all rresp=OKAY.
- Write to 0x400 (out of range, depth 256) -> bresp=SLVERR; memory unchanged. Read of 0x400 -> rdata=0, rresp=SLVERR.
- rready low for 3 cycles mid-burst -> rdata/rlast stable, no beat lost. Later, bready low 5 cycles -> bvalid held and awready stays 0.
- wstrb=4'b0101 over word 0xFFFFFFFF with wdata 0x11223344 -> readback 0xFF22FF44.
- rst asserted during beat 2 of a 4-beat write -> outputs zero asynchronously. After release, awready=1 and a new burst completes with OKAY.
